// File: rtl/des_match_collector_pkg.sv
// Shared types and constants for the DES match collector.
package des_match_collector_pkg;

    localparam int unsigned DES_W     = 64;
    localparam int unsigned N_DEF     = 64;
    localparam int unsigned CNT_W_DEF = 32;
    localparam int unsigned DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Ciphertext matches when every bit selected by mask equals the target.
    function automatic logic masked_eq(input logic [DES_W-1:0] cipher,
                                       input logic [DES_W-1:0] target,
                                       input logic [DES_W-1:0] mask);
        return ((cipher ^ target) & mask) == '0;
    endfunction

endpackage

// File: rtl/des_match_collector_if.sv
// Pair input and hit output handshake bundle for the DES match collector.
interface des_match_collector_if
    import des_match_collector_pkg::*;
#(
    parameter int unsigned N = N_DEF
);

    logic             in_valid;
    logic [N-1:0]     in_msg;
    logic [DES_W-1:0] in_cipher;
    logic             hit_valid;
    logic             hit_ready;
    logic [N-1:0]     hit_msg;

    modport master (
        output in_valid, in_msg, in_cipher, hit_ready,
        input  hit_valid, hit_msg
    );

    modport slave (
        input  in_valid, in_msg, in_cipher, hit_ready,
        output hit_valid, hit_msg
    );

endinterface

// File: rtl/des_match_collector_hit_fifo.sv
// Synchronous FIFO with first-word fall-through head and synchronous clear.
module des_match_collector_hit_fifo #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic          do_push_c;
    logic          do_pop_c;

    // Extra pointer bit distinguishes full from empty when indices coincide.
    assign empty_o   = (wr_q == rd_q);
    assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop_c  = pop_i && !empty_o;
    assign do_push_c = push_i && (!full_o || do_pop_c);
    assign dout_o    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (clr_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push_c) wr_d = wr_q + PW'(1);
            if (do_pop_c)  rd_d = rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c && !clr_i) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/des_match_collector.sv
// Compares DES results against a masked target, counts pairs/matches and
// buffers matching messages for the host.
module des_match_collector
    import des_match_collector_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DES_W-1:0]     target,
    input  logic [DES_W-1:0]     mask,
    input  logic                 src_done,
    des_match_collector_if.slave bus,
    output logic [CNT_W-1:0]     processed_count,
    output logic [CNT_W-1:0]     match_count,
    output logic                 overflow,
    output logic                 done
);

    state_e           state_q, state_d;
    logic             stage_vld_q, stage_vld_d;
    logic             stage_eq_q, stage_eq_d;
    logic [N-1:0]     stage_msg_q, stage_msg_d;
    logic [CNT_W-1:0] processed_q, processed_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic             accept_c;
    logic             hit_c;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop_c;

    // start wins over any pair or stage retirement in the same cycle.
    assign accept_c   = (state_q == ST_COLLECT) && bus.in_valid && !start;
    assign hit_c      = stage_vld_q && stage_eq_q && !start;
    assign fifo_pop_c = bus.hit_ready && !fifo_empty;

    always_comb begin
        state_d     = state_q;
        stage_vld_d = accept_c;
        stage_eq_d  = accept_c && masked_eq(bus.in_cipher, target, mask);
        stage_msg_d = accept_c ? bus.in_msg : stage_msg_q;
        processed_d = processed_q;
        match_d     = match_q;
        ovf_d       = ovf_q;

        if (start) begin
            processed_d = '0;
            match_d     = '0;
            ovf_d       = 1'b0;
        end else begin
            if (accept_c && (processed_q != '1)) processed_d = processed_q + CNT_W'(1);
            if (hit_c && (match_q != '1))        match_d     = match_q + CNT_W'(1);
            if (hit_c && fifo_full && !fifo_pop_c) ovf_d     = 1'b1;
        end

        case (state_q)
            ST_IDLE:    state_d = ST_IDLE;
            ST_COLLECT: if (src_done) state_d = ST_DRAIN;
            ST_DRAIN:   if (!stage_vld_d) state_d = ST_DONE;
            ST_DONE:    state_d = ST_DONE;
            default:    state_d = ST_IDLE;
        endcase
        if (start) state_d = ST_COLLECT;

        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            stage_vld_q <= 1'b0;
            stage_eq_q  <= 1'b0;
            stage_msg_q <= '0;
            processed_q <= '0;
            match_q     <= '0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_vld_q <= stage_vld_d;
            stage_eq_q  <= stage_eq_d;
            stage_msg_q <= stage_msg_d;
            processed_q <= processed_d;
            match_q     <= match_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
        end
    end

    des_match_collector_hit_fifo #(
        .W     (N),
        .DEPTH (DEPTH)
    ) u_hit_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (start),
        .push_i  (hit_c),
        .pop_i   (bus.hit_ready),
        .din_i   (stage_msg_q),
        .dout_o  (bus.hit_msg),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.hit_valid   = !fifo_empty;
    assign processed_count = processed_q;
    assign match_count     = match_q;
    assign overflow        = ovf_q;
    assign done            = done_q;

endmodule

// File: tb/tb_des_match_collector.sv
// Directed bench for des_match_collector, plus a narrow-counter instance for saturation.
module tb_des_match_collector;

    localparam logic [63:0] TGT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] ONES = '1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        src_done;
    logic [63:0] target;
    logic [63:0] mask;

    logic [31:0] processed_count, match_count;
    logic        overflow, done;
    logic [3:0]  sat_processed, sat_match;
    logic        sat_overflow, sat_done;

    int errors = 0;
    int checks = 0;

    des_match_collector_if #(.N(64)) dut_if ();
    des_match_collector_if #(.N(64)) sat_if ();

    assign sat_if.in_valid  = dut_if.in_valid;
    assign sat_if.in_msg    = dut_if.in_msg;
    assign sat_if.in_cipher = dut_if.in_cipher;
    assign sat_if.hit_ready = 1'b1;

    des_match_collector #(.N(64), .DEPTH(4), .CNT_W(32)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .target          (target),
        .mask            (mask),
        .src_done        (src_done),
        .bus             (dut_if),
        .processed_count (processed_count),
        .match_count     (match_count),
        .overflow        (overflow),
        .done            (done)
    );

    des_match_collector #(.N(64), .DEPTH(4), .CNT_W(4)) u_sat (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .target          (target),
        .mask            (mask),
        .src_done        (src_done),
        .bus             (sat_if),
        .processed_count (sat_processed),
        .match_count     (sat_match),
        .overflow        (sat_overflow),
        .done            (sat_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic put(input logic [63:0] msg, input logic [63:0] cipher);
        dut_if.in_valid  = 1'b1;
        dut_if.in_msg    = msg;
        dut_if.in_cipher = cipher;
        step();
        dut_if.in_valid  = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        start            = 1'b0;
        src_done         = 1'b0;
        target           = TGT;
        mask             = ONES;
        dut_if.in_valid  = 1'b0;
        dut_if.in_msg    = '0;
        dut_if.in_cipher = '0;
        dut_if.hit_ready = 1'b0;
        step();
        step();
        chk("rst_hit_valid", 64'(dut_if.hit_valid), 64'd0);
        chk("rst_processed", 64'(processed_count), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        step();

        // Single match among five pairs with a full mask.
        pulse_start();
        for (int i = 1; i <= 5; i++) begin
            put(64'h100 + 64'(i), (i == 3) ? TGT : (TGT ^ 64'(i)));
            if (i == 3) chk("t2_hit_not_yet", 64'(dut_if.hit_valid), 64'd0);
            if (i == 4) begin
                chk("t2_hit_valid", 64'(dut_if.hit_valid), 64'd1);
                chk("t2_hit_msg", dut_if.hit_msg, 64'h103);
                chk("t2_match_lat", 64'(match_count), 64'd1);
            end
        end
        chk("t2_processed", 64'(processed_count), 64'd5);
        chk("t2_match", 64'(match_count), 64'd1);
        dut_if.hit_ready = 1'b1;
        step();
        dut_if.hit_ready = 1'b0;
        chk("t2_popped_empty", 64'(dut_if.hit_valid), 64'd0);

        // Overflow: mask=0, six pairs into a 4-deep FIFO without pops.
        pulse_start();
        mask = '0;
        for (int i = 1; i <= 6; i++) put(64'h200 + 64'(i), 64'(i));
        step();
        step();
        chk("t3_match", 64'(match_count), 64'd6);
        chk("t3_processed", 64'(processed_count), 64'd6);
        chk("t3_overflow", 64'(overflow), 64'd1);
        dut_if.hit_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("t3_pop_valid", 64'(dut_if.hit_valid), 64'd1);
            chk("t3_pop_msg", dut_if.hit_msg, 64'h200 + 64'(k));
            step();
        end
        chk("t3_drained", 64'(dut_if.hit_valid), 64'd0);
        dut_if.hit_ready = 1'b0;

        // Full FIFO with simultaneous push and pop loses nothing.
        pulse_start();
        chk("t4_ovf_cleared", 64'(overflow), 64'd0);
        for (int i = 1; i <= 4; i++) put(64'h300 + 64'(i), 64'(i));
        step();
        step();
        chk("t4_fill_match", 64'(match_count), 64'd4);
        chk("t4_fill_head", dut_if.hit_msg, 64'h301);
        for (int j = 5; j <= 10; j++) begin
            if (j == 6) dut_if.hit_ready = 1'b1;
            if (j >= 6) chk("t4_head", dut_if.hit_msg, 64'h300 + 64'(j - 5));
            dut_if.in_valid  = 1'b1;
            dut_if.in_msg    = 64'h300 + 64'(j);
            dut_if.in_cipher = 64'(j);
            step();
        end
        dut_if.in_valid = 1'b0;
        for (int k = 6; k <= 10; k++) begin
            chk("t4_tail", dut_if.hit_msg, 64'h300 + 64'(k));
            step();
        end
        chk("t4_empty", 64'(dut_if.hit_valid), 64'd0);
        chk("t4_no_ovf", 64'(overflow), 64'd0);
        chk("t4_match", 64'(match_count), 64'd10);
        dut_if.hit_ready = 1'b0;

        // End of run: src_done with the last pair, then ignore, then restart.
        pulse_start();
        mask = ONES;
        put(64'h501, ~TGT);
        src_done = 1'b1;
        put(64'h502, TGT);
        chk("t5_done_early", 64'(done), 64'd0);
        chk("t5_processed", 64'(processed_count), 64'd2);
        put(64'h5FF, TGT);
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_match", 64'(match_count), 64'd1);
        chk("t5_hit_msg", dut_if.hit_msg, 64'h502);
        put(64'h5FE, TGT);
        chk("t5_ignored", 64'(processed_count), 64'd2);
        chk("t5_done_hold", 64'(done), 64'd1);
        src_done = 1'b0;
        pulse_start();
        chk("t5_restart_proc", 64'(processed_count), 64'd0);
        chk("t5_restart_match", 64'(match_count), 64'd0);
        chk("t5_restart_done", 64'(done), 64'd0);
        chk("t5_restart_fifo", 64'(dut_if.hit_valid), 64'd0);

        // Saturation on the 4-bit counter instance.
        pulse_start();
        mask = '0;
        dut_if.hit_ready = 1'b1;
        for (int i = 1; i <= 20; i++) put(64'h600 + 64'(i), 64'(i));
        step();
        step();
        chk("t6_sat_processed", 64'(sat_processed), 64'd15);
        chk("t6_sat_match", 64'(sat_match), 64'd15);
        chk("t6_wide_processed", 64'(processed_count), 64'd20);
        chk("t6_wide_match", 64'(match_count), 64'd20);

        // Asynchronous reset mid-COLLECT with two hits buffered.
        dut_if.hit_ready = 1'b0;
        pulse_start();
        put(64'h701, 64'd1);
        put(64'h702, 64'd2);
        step();
        step();
        chk("t1_pre_hits", 64'(match_count), 64'd2);
        chk("t1_pre_valid", 64'(dut_if.hit_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t1_hit_valid", 64'(dut_if.hit_valid), 64'd0);
        chk("t1_processed", 64'(processed_count), 64'd0);
        chk("t1_match", 64'(match_count), 64'd0);
        chk("t1_overflow", 64'(overflow), 64'd0);
        chk("t1_done", 64'(done), 64'd0);
        step();
        rst_n = 1'b1;
        put(64'h703, 64'd3);
        step();
        chk("t1_idle_ignores", 64'(processed_count), 64'd0);
        chk("t1_idle_nohit", 64'(dut_if.hit_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
